seg7_mux_ctrl: RTL and testbench
================================

Name: seg7_mux_ctrl

Overview:
Parametrised time-multiplexed 7-segment display driver for N common-anode/cathode digits.
- Scans one digit per refresh slot.
- Decodes BCD or hex nibbles and drives per-digit decimal points.
- Applies leading-zero blanking, a per-digit blank mask and PWM brightness.
- Snapshots its inputs once per full scan frame so the display never shows a torn value.
- Sits between the counter/datapath logic and the board's segment/anode pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
DIGIT_TICKS, 50000, clk cycles per digit slot (1 ms at 50 MHz), >= 2^PWM_BITS
PWM_BITS, 3, brightness resolution in bits
SEG_ACTIVE_LOW, 1, 1 = a lit segment drives 0
DIG_ACTIVE_LOW, 0, 1 = selected digit drives 0

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
value  input  4*NUM_DIGITS  nibble per digit; [3:0] = digit 0 (ones)
dp  input  NUM_DIGITS  decimal point request per digit
blank  input  NUM_DIGITS  1 = force digit dark
hex_mode  input  1  1 = show codes 10..15 as A,b,C,d,E,F
lzb_en  input  1  leading-zero blanking enable
brightness  input  PWM_BITS  on-time code; all-ones = 100%
seg  output  8  segments, bit7..bit1 = a..g, bit0 = dp
digit  output  NUM_DIGITS  one-hot digit enable; bit0 = ones
frame_start  output  1  one-cycle pulse when a new snapshot is taken

Behaviour:
Reset (async, rst=1):
- timer=0, idx=0, snapshot registers cleared, load_pending=1.
- seg = all segments inactive; digit = all inactive; frame_start=0.

Timer and scan:
- timer counts 0..DIGIT_TICKS-1 and wraps to 0.
- On the wrap cycle, idx increments; idx = NUM_DIGITS-1 wraps to 0.
- Snapshot: when idx wraps to 0, or on the first edge after reset release (load_pending), the block registers value, dp, blank, hex_mode, lzb_en and brightness, pulses frame_start for one cycle, and clears load_pending.
- Input changes mid-frame have no visible effect until the next snapshot.

Decode, active-high form before polarity (a..g, dp=0):
- 0=11111100, 1=01100000, 2=11011010, 3=11110010, 4=01100110
- 5=10110110, 6=10111110, 7=11100000, 8=11111110, 9=11110110
- hex_mode=1: A=11101110, b=00111110, C=10011100, d=01111010, E=10011110, F=10001110
- hex_mode=0: codes 10..15 show dash = 00000010
- bit0 = snapshot dp[idx].

Leading-zero blanking (lzb_en=1):
- digit k is dark if its nibble is 0 AND every more-significant nibble is 0 AND dp[k]=0.
- Digit 0 is never blanked by LZB, so value 0 shows a single "0".

blank[k]=1: digit k is dark, dp included.

Dark digit: seg inactive and the digit bit inactive for the whole slot.

Brightness:
- on_ticks = ((brightness+1)*DIGIT_TICKS) >> PWM_BITS, computed from the snapshot at snapshot time.
- Digit is enabled while timer < on_ticks; for the rest of the slot both seg and digit are inactive.
- brightness=all-ones gives continuous on.

Outputs and timing:
- seg and digit are registered and reflect idx/timer with 1-cycle latency.
- At most one digit bit is active at any time.
- At every slot boundary, segments of the new digit and the new anode change on the same edge.
- Polarity parameters invert only the final output registers.

Test Plan:
- Reset, then release with value=16'h1234, all other controls default, brightness=7 -> frame_start pulses on the first edge after release. Slots show 4,3,2,1 on digit=0001,0010,0100,1000. seg for "4" = 8'b10011001 (active-low).
- value=16'h0070, lzb_en=1 -> digits 3 and 2 dark (digit bits inactive); digit 1 shows "7"; digit 0 shows "0". With lzb_en=0, all four digits show.
- value=16'h00AF: hex_mode=1 -> "F" then "A"; hex_mode=0 -> dash (8'b11111101) in both slots.
- brightness=3, PWM_BITS=3, DIGIT_TICKS=8 -> each digit is active exactly 4 of 8 cycles per slot, starting at slot start.
- Change value mid-frame at idx=2 -> remaining slots keep the old digits; the new value appears only after the next frame_start.
- Assert rst mid-slot -> seg/digit immediately inactive, with no clk edge required. After release, scanning restarts at digit 0 with a fresh snapshot.

Source files
------------

// File: rtl/seg7_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg7_mux_ctrl
// Description : Time-multiplexed 7-segment display driver. Scans one digit per
//               refresh slot, decodes BCD/hex nibbles with decimal points,
//               applies leading-zero blanking, a per-digit blank mask and PWM
//               brightness. All display inputs are snapshotted once per full
//               scan frame so a frame never shows a torn value.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               i_value           - 4 bits per digit, [3:0] = digit 0 (ones)
//               i_dp, i_blank     - per-digit decimal point / force-dark
//               i_hex_mode        - show 10..15 as A..F instead of a dash
//               i_lzb_en          - leading-zero blanking enable
//               i_brightness      - PWM on-time code, all-ones = 100%
//               o_seg             - {a,b,c,d,e,f,g,dp}
//               o_digit           - one-hot digit enable, bit0 = ones
//               o_frame_start     - one-cycle pulse when a snapshot is taken
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_mux_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_TICKS    = 50000,
    parameter int PWM_BITS       = 3,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   i_value,
    input  logic [NUM_DIGITS-1:0]     i_dp,
    input  logic [NUM_DIGITS-1:0]     i_blank,
    input  logic                      i_hex_mode,
    input  logic                      i_lzb_en,
    input  logic [PWM_BITS-1:0]       i_brightness,
    output logic [7:0]                o_seg,
    output logic [NUM_DIGITS-1:0]     o_digit,
    output logic                      o_frame_start
);

    // Timer is wide enough to hold DIGIT_TICKS itself, which is the on-time
    // value for full brightness.
    localparam int c_TW = $clog2(DIGIT_TICKS + 1);
    localparam int c_IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_TW-1:0]       c_T_LAST  = c_TW'(DIGIT_TICKS - 1);
    localparam logic [c_IW-1:0]       c_I_LAST  = c_IW'(NUM_DIGITS - 1);
    localparam logic [7:0]            c_SEG_INV = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] c_DIG_INV = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    logic [c_TW-1:0]           r_timer;
    logic [c_IW-1:0]           r_idx;
    logic                      r_load_pending;
    logic [4*NUM_DIGITS-1:0]   r_val;
    logic [NUM_DIGITS-1:0]     r_dp;
    logic [NUM_DIGITS-1:0]     r_blank;
    logic                      r_hex;
    logic                      r_lzb;
    logic [c_TW-1:0]           r_on_ticks;
    logic [7:0]                r_seg;
    logic [NUM_DIGITS-1:0]     r_digit;
    logic                      r_frame_start;

    logic                      w_wrap;
    logic                      w_snap;
    logic [NUM_DIGITS-1:0]     w_lzb_dark;
    logic [3:0]                w_nib;
    logic                      w_dp_cur;
    logic                      w_dark;
    logic [NUM_DIGITS-1:0]     w_onehot;
    logic [6:0]                w_seg_ah;
    logic                      w_lit;

    assign w_wrap = (r_timer == c_T_LAST);
    assign w_snap = r_load_pending || (w_wrap && (r_idx == c_I_LAST));

    // A digit is LZB-dark when it and everything above it is zero and it has
    // no decimal point. Digit 0 is exempt so an all-zero value shows "0".
    always_comb begin : p_lzb
        logic w_zero_above;
        w_zero_above = 1'b1;
        w_lzb_dark   = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (k != 0) begin
                w_lzb_dark[k] = r_lzb && w_zero_above &&
                                (r_val[4*k +: 4] == 4'd0) && !r_dp[k];
            end
            w_zero_above = w_zero_above && (r_val[4*k +: 4] == 4'd0);
        end
    end

    always_comb begin : p_select
        w_nib    = 4'd0;
        w_dp_cur = 1'b0;
        w_dark   = 1'b0;
        w_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == c_IW'(k)) begin
                w_nib       = r_val[4*k +: 4];
                w_dp_cur    = r_dp[k];
                w_dark      = r_blank[k] || w_lzb_dark[k];
                w_onehot[k] = 1'b1;
            end
        end
    end

    // Active-high a..g
    always_comb begin : p_decode
        w_seg_ah = 7'b0000001;
        case (w_nib)
            4'h0:    w_seg_ah = 7'b1111110;
            4'h1:    w_seg_ah = 7'b0110000;
            4'h2:    w_seg_ah = 7'b1101101;
            4'h3:    w_seg_ah = 7'b1111001;
            4'h4:    w_seg_ah = 7'b0110011;
            4'h5:    w_seg_ah = 7'b1011011;
            4'h6:    w_seg_ah = 7'b1011111;
            4'h7:    w_seg_ah = 7'b1110000;
            4'h8:    w_seg_ah = 7'b1111111;
            4'h9:    w_seg_ah = 7'b1111011;
            4'hA:    w_seg_ah = r_hex ? 7'b1110111 : 7'b0000001;
            4'hB:    w_seg_ah = r_hex ? 7'b0011111 : 7'b0000001;
            4'hC:    w_seg_ah = r_hex ? 7'b1001110 : 7'b0000001;
            4'hD:    w_seg_ah = r_hex ? 7'b0111101 : 7'b0000001;
            4'hE:    w_seg_ah = r_hex ? 7'b1001111 : 7'b0000001;
            default: w_seg_ah = r_hex ? 7'b1000111 : 7'b0000001;
        endcase
    end

    assign w_lit = !w_dark && (r_timer < r_on_ticks);

    // Scan timer and digit index. The timer is held while the post-reset
    // snapshot is pending so the first slot starts aligned to frame_start,
    // exactly like every later frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer        <= '0;
            r_idx          <= '0;
            r_load_pending <= 1'b1;
        end else begin
            r_load_pending <= 1'b0;
            if (!r_load_pending) begin
                if (w_wrap) begin
                    r_timer <= '0;
                    r_idx   <= (r_idx == c_I_LAST) ? '0 : r_idx + 1'b1;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end
        end
    end

    // Frame snapshot. A cleared r_on_ticks keeps the display dark until the
    // first real snapshot lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val         <= '0;
            r_dp          <= '0;
            r_blank       <= '0;
            r_hex         <= 1'b0;
            r_lzb         <= 1'b0;
            r_on_ticks    <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_snap;
            if (w_snap) begin
                r_val      <= i_value;
                r_dp       <= i_dp;
                r_blank    <= i_blank;
                r_hex      <= i_hex_mode;
                r_lzb      <= i_lzb_en;
                r_on_ticks <= c_TW'(((32'(i_brightness) + 32'd1) * 32'(DIGIT_TICKS)) >> PWM_BITS);
            end
        end
    end

    // Output registers carry the pin polarity so reset lands on "inactive".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg   <= c_SEG_INV;
            r_digit <= c_DIG_INV;
        end else begin
            r_seg   <= (w_lit ? {w_seg_ah, w_dp_cur} : 8'h00) ^ c_SEG_INV;
            r_digit <= (w_lit ? w_onehot : '0) ^ c_DIG_INV;
        end
    end

    assign o_seg         = r_seg;
    assign o_digit       = r_digit;
    assign o_frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg7_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_mux_ctrl
// Description : Self-checking bench for seg7_mux_ctrl (4 digits, 8 ticks per
//               slot, 3-bit PWM, active-low segments, active-high digits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_mux_ctrl;

    localparam int ND = 4;
    localparam int DT = 8;
    localparam int PB = 3;
    localparam int FRAME = ND * DT;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        hex;
        logic        lzb;
        logic [2:0]  bright;
    } snap_t;

    typedef struct {
        snap_t            s;
        logic [3:0][7:0]  seg;   // pin value at slot start, per digit
        logic [3:0][3:0]  on;    // active ticks per slot, per digit
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic        hex_mode = 1'b0;
    logic        lzb_en = 1'b0;
    logic [2:0]  brightness = 3'd7;
    logic [7:0]  seg;
    logic [3:0]  digit;
    logic        frame_start;

    int n_pass = 0;
    int n_total = 0;

    seg7_mux_ctrl #(
        .NUM_DIGITS    (ND),
        .DIGIT_TICKS   (DT),
        .PWM_BITS      (PB),
        .SEG_ACTIVE_LOW(1),
        .DIG_ACTIVE_LOW(0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_value      (value),
        .i_dp         (dp),
        .i_blank      (blank),
        .i_hex_mode   (hex_mode),
        .i_lzb_en     (lzb_en),
        .i_brightness (brightness),
        .o_seg        (seg),
        .o_digit      (digit),
        .o_frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Active-high a..g for a displayed nibble.
    function automatic logic [6:0] pattern(int nib, logic hx);
        logic [6:0] p;
        case (nib)
            0: p = 7'b1111110;  1: p = 7'b0110000;  2: p = 7'b1101101;
            3: p = 7'b1111001;  4: p = 7'b0110011;  5: p = 7'b1011011;
            6: p = 7'b1011111;  7: p = 7'b1110000;  8: p = 7'b1111111;
            9: p = 7'b1111011; 10: p = 7'b1110111; 11: p = 7'b0011111;
           12: p = 7'b1001110; 13: p = 7'b0111101; 14: p = 7'b1001111;
           default: p = 7'b1000111;
        endcase
        if (nib > 9 && !hx) p = 7'b0000001;
        return p;
    endfunction

    // Expected {seg pins, digit pins} for digit k at tick t of its slot.
    function automatic logic [11:0] model(snap_t s, int k, int t);
        int         v, nib, on_t;
        logic       lzb_dark, lit;
        logic [7:0] sg;
        logic [3:0] dg;
        v        = int'(s.value);
        nib      = (v >> (4 * k)) % 16;
        on_t     = ((int'(s.bright) + 1) * DT) / (1 << PB);
        lzb_dark = s.lzb && (k > 0) && ((v >> (4 * k)) == 0) && !s.dp[k];
        lit      = !s.blank[k] && !lzb_dark && (t < on_t);
        sg       = lit ? {pattern(nib, s.hex), s.dp[k]} : 8'h00;
        dg       = lit ? 4'(1 << k) : 4'h0;
        return {~sg, dg};
    endfunction

    task automatic apply(input snap_t s);
        value = s.value; dp = s.dp; blank = s.blank;
        hex_mode = s.hex; lzb_en = s.lzb; brightness = s.bright;
    endtask

    task automatic wait_fs();
        bit got = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = frame_start;
        end
        chk("frame_start timeout", 32'(got), 32'd1);
    endtask

    // Checks one full frame, starting right after a frame_start sample.
    // Optionally changes the inputs to s2 partway through digit 2's slot.
    task automatic check_frame(input snap_t s, input string nm, input bit chg,
                               input snap_t s2, output logic [3:0][7:0] seg0,
                               output logic [3:0][3:0] oncnt);
        int k, t;
        seg0  = '0;
        oncnt = '0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            k = i / DT;
            t = i % DT;
            chk($sformatf("%s out k%0d t%0d", nm, k, t), 32'({seg, digit}), 32'(model(s, k, t)));
            chk($sformatf("%s frame_start i%0d", nm, i), 32'(frame_start), 32'(i == FRAME - 1));
            if (t == 0) seg0[k] = seg;
            if (digit[k]) oncnt[k] = oncnt[k] + 4'd1;
            if (chg && i == 2 * DT + 3) apply(s2);
        end
    endtask

    // Asserts reset between clock edges and checks the outputs drop at once.
    task automatic do_reset(input string nm);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk({nm, " async seg"}, 32'(seg), 32'hFF);
        chk({nm, " async digit"}, 32'(digit), 32'h0);
        chk({nm, " async fs"}, 32'(frame_start), 32'h0);
        repeat (3) @(negedge clk);
        chk({nm, " held out"}, 32'({seg, digit, frame_start}), 32'({8'hFF, 4'h0, 1'b0}));
        rst = 1'b0;
        @(negedge clk);
        chk({nm, " first fs"}, 32'(frame_start), 32'd1);
    endtask

    function automatic vec_t mk(logic [15:0] v, logic [3:0] d, logic [3:0] b,
                                logic h, logic l, logic [2:0] br,
                                logic [3:0][7:0] sg, logic [3:0][3:0] on);
        vec_t r;
        r.s.value = v; r.s.dp = d; r.s.blank = b;
        r.s.hex = h; r.s.lzb = l; r.s.bright = br;
        r.seg = sg; r.on = on;
        return r;
    endfunction

    vec_t             vecs[12];
    logic [3:0][7:0]  s0;
    logic [3:0][3:0]  oc;
    snap_t            sa, sb, sr;

    initial begin
        // seg and on lists are written digit3..digit0
        vecs[0]  = mk(16'h1234, 4'h0, 4'h0, 0, 0, 3'd7, {8'h9F, 8'h25, 8'h0D, 8'h99}, {4'd8, 4'd8, 4'd8, 4'd8});
        vecs[1]  = mk(16'h0070, 4'h0, 4'h0, 0, 1, 3'd7, {8'hFF, 8'hFF, 8'h1F, 8'h03}, {4'd0, 4'd0, 4'd8, 4'd8});
        vecs[2]  = mk(16'h0070, 4'h0, 4'h0, 0, 0, 3'd7, {8'h03, 8'h03, 8'h1F, 8'h03}, {4'd8, 4'd8, 4'd8, 4'd8});
        vecs[3]  = mk(16'h00AF, 4'h0, 4'h0, 1, 0, 3'd7, {8'h03, 8'h03, 8'h11, 8'h71}, {4'd8, 4'd8, 4'd8, 4'd8});
        vecs[4]  = mk(16'h00AF, 4'h0, 4'h0, 0, 0, 3'd7, {8'h03, 8'h03, 8'hFD, 8'hFD}, {4'd8, 4'd8, 4'd8, 4'd8});
        vecs[5]  = mk(16'h1234, 4'h0, 4'h0, 0, 0, 3'd3, {8'h9F, 8'h25, 8'h0D, 8'h99}, {4'd4, 4'd4, 4'd4, 4'd4});
        vecs[6]  = mk(16'h0000, 4'h4, 4'h0, 0, 1, 3'd7, {8'hFF, 8'h02, 8'hFF, 8'h03}, {4'd0, 4'd8, 4'd0, 4'd8});
        vecs[7]  = mk(16'h5678, 4'h3, 4'h2, 0, 0, 3'd7, {8'h49, 8'h41, 8'hFF, 8'h00}, {4'd8, 4'd8, 4'd0, 4'd8});
        vecs[8]  = mk(16'h9999, 4'h0, 4'h0, 0, 0, 3'd0, {8'h09, 8'h09, 8'h09, 8'h09}, {4'd1, 4'd1, 4'd1, 4'd1});
        vecs[9]  = mk(16'h0000, 4'h0, 4'h0, 0, 1, 3'd7, {8'hFF, 8'hFF, 8'hFF, 8'h03}, {4'd0, 4'd0, 4'd0, 4'd8});
        vecs[10] = mk(16'hCDEB, 4'h0, 4'h0, 1, 1, 3'd7, {8'h63, 8'h85, 8'h61, 8'hC1}, {4'd8, 4'd8, 4'd8, 4'd8});
        vecs[11] = mk(16'h5060, 4'h0, 4'h0, 0, 1, 3'd5, {8'h49, 8'h03, 8'h41, 8'h03}, {4'd6, 4'd6, 4'd6, 4'd6});

        // Table vectors; the first one goes through reset release.
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].s);
            if (i == 0) do_reset("reset");
            else wait_fs();
            check_frame(vecs[i].s, $sformatf("vec%0d", i), 1'b0, vecs[i].s, s0, oc);
            for (int k = 0; k < ND; k++) begin
                chk($sformatf("vec%0d seg d%0d", i, k), 32'(s0[k]), 32'(vecs[i].seg[k]));
                chk($sformatf("vec%0d on d%0d", i, k), 32'(oc[k]), 32'(vecs[i].on[k]));
            end
        end

        // Mid-frame input change: current frame keeps the old value.
        sa = vecs[0].s;
        sb = sa;
        sb.value = 16'h8765;
        apply(sa);
        wait_fs();
        check_frame(sa, "midA", 1'b1, sb, s0, oc);
        check_frame(sb, "midB", 1'b0, sb, s0, oc);

        // Reset in the middle of digit 1's slot, then a fresh frame.
        apply(sa);
        wait_fs();
        repeat (DT + 3) @(negedge clk);
        do_reset("midreset");
        check_frame(sa, "postrst", 1'b0, sa, s0, oc);

        // Randomised frames against the reference model.
        for (int r = 0; r < 10; r++) begin
            sr.value  = 16'($urandom);
            if (r % 3 == 0) sr.value = sr.value & 16'h00FF;
            sr.dp     = 4'($urandom);
            sr.blank  = 4'($urandom_range(0, 15)) & 4'($urandom);
            sr.hex    = 1'($urandom);
            sr.lzb    = 1'($urandom);
            sr.bright = 3'($urandom_range(0, 7));
            apply(sr);
            wait_fs();
            check_frame(sr, $sformatf("rand%0d", r), 1'b0, sr, s0, oc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
